state_timer: RTL and testbench

STATE_TIMER -- requirements
Module: state_timer

---
 rtl/train_timer_pkg.sv | 30 +++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/state_timer.sv | 103 ++++++++++
 tb/tb_state_timer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/train_timer_pkg.sv
// Shared types, state codes and the dwell-time table for the train state timer.
package train_timer_pkg;

    localparam int unsigned DEF_STATE_W = 4;
    localparam int unsigned DEF_TIME_W  = 19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } fsm_e;

    localparam logic [DEF_STATE_W-1:0] CODE_BOARDING = 4'b0000;
    localparam logic [DEF_STATE_W-1:0] CODE_WARNING  = 4'b0011;
    localparam logic [DEF_STATE_W-1:0] CODE_DEPART   = 4'b0100;

    localparam int unsigned DUR_LONG_MS  = 2000;
    localparam int unsigned DUR_SHORT_MS = 1000;

    // Codes without a table entry have no dwell and park the timer in IDLE.
    function automatic int unsigned dwell_ms(input int unsigned code);
        case (code)
            32'(CODE_BOARDING): return DUR_LONG_MS;
            32'(CODE_WARNING):  return DUR_SHORT_MS;
            32'(CODE_DEPART):   return DUR_LONG_MS;
            default:            return 0;
        endcase
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and pulses tick on the last count.
module ms_tick_gen #(
    parameter int unsigned CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CNT_W = $clog2(CLK_PER_MS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;

    // Gating with en keeps a frozen counter from holding tick high.
    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/state_timer.sv
// Dwell timer for a train controller: reloads on every state change and counts
// down in ms. Optional freeze input enabled by the TIMER_PAUSE_EN macro.
module state_timer
    import train_timer_pkg::*;
#(
    parameter int unsigned STATE_W    = DEF_STATE_W,
    parameter int unsigned TIME_W     = DEF_TIME_W,
    parameter int unsigned CLK_PER_MS = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] present_state,
`ifdef TIMER_PAUSE_EN
    input  logic               pause,
`endif
    output logic [TIME_W-1:0]  t,
    output logic [TIME_W-1:0]  remaining,
    output logic               busy,
    output logic               expired,
    output logic               done
);

    fsm_e               state_q;
    logic [STATE_W-1:0] prev_state_q;
    logic               first_q;
    logic [TIME_W-1:0]  t_q;
    logic [TIME_W-1:0]  remaining_q;
    logic               busy_q;
    logic               expired_q;
    logic               done_q;

    logic               change;
    logic               freeze;
    logic               tick;
    logic [TIME_W-1:0]  dur;

    // The first edge out of reset reloads even if the code matches prev_state.
    assign change = first_q || (present_state != prev_state_q);
    assign dur    = TIME_W'(dwell_ms(32'(present_state)));

`ifdef TIMER_PAUSE_EN
    assign freeze = pause && (state_q == ST_RUN);
`else
    assign freeze = 1'b0;
`endif

    ms_tick_gen #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (change),
        .en   (!freeze),
        .tick (tick)
    );

    // NOTE: all state uses <= so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_state_q <= '0;
            first_q      <= 1'b1;
            t_q          <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            expired_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            first_q      <= 1'b0;
            prev_state_q <= present_state;
            expired_q    <= 1'b0;
            if (change) begin
                t_q         <= dur;
                remaining_q <= dur;
                done_q      <= 1'b0;
                if (dur != '0) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (state_q == ST_RUN && tick) begin
                if (remaining_q == TIME_W'(1)) begin
                    remaining_q <= '0;
                    state_q     <= ST_EXPIRED;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    expired_q   <= 1'b1;
                end else if (remaining_q != '0) begin
                    remaining_q <= remaining_q - TIME_W'(1);
                end
            end
        end
    end

    assign t         = t_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign expired   = expired_q;
    assign done      = done_q;

endmodule

// File: tb/tb_state_timer.sv
// Self-checking bench for state_timer (CLK_PER_MS=4) against an elapsed-cycle
// reference model; build with +define+TIMER_PAUSE_EN to exercise the freeze input.
module tb_state_timer;

    localparam int CPM = 4;
`ifdef TIMER_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  present_state;
    logic        pause;
    logic [18:0] t;
    logic [18:0] remaining;
    logic        busy;
    logic        expired;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    state_timer #(
        .STATE_W    (4),
        .TIME_W     (19),
        .CLK_PER_MS (CPM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .present_state (present_state),
`ifdef TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .t             (t),
        .remaining     (remaining),
        .busy          (busy),
        .expired       (expired),
        .done          (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int dur_of(input logic [3:0] c);
        case (c)
            4'b0000: return 2000;
            4'b0011: return 1000;
            4'b0100: return 2000;
            default: return 0;
        endcase
    endfunction

    // Reference model: a dwell of D ms lasts D*CPM un-paused cycles after the load
    // edge; remaining is D minus the whole ms elapsed so far.
    int         m_t, m_rem, m_elapsed;
    bit         m_busy, m_done, m_exp, m_first, model_valid;
    logic [3:0] m_prev;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_rem = 0; m_elapsed = 0;
            m_busy = 0; m_done = 0; m_exp = 0;
            m_first = 1; m_prev = 4'd0;
        end else begin
            m_exp = 0;
            if (m_first || present_state != m_prev) begin
                m_t = dur_of(present_state);
                m_rem = m_t;
                m_elapsed = 0;
                m_busy = (m_t != 0);
                m_done = 0;
            end else if (m_busy && !(PAUSE_ON && pause)) begin
                m_elapsed++;
                m_rem = m_t - m_elapsed / CPM;
                if (m_elapsed == m_t * CPM) begin
                    m_busy = 0; m_done = 1; m_exp = 1;
                end
            end
            m_first = 0;
            m_prev = present_state;
        end
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("t",         32'(t),         32'(m_t));
            check("remaining", 32'(remaining), 32'(m_rem));
            check("busy",      32'(busy),      32'(m_busy));
            check("expired",   32'(expired),   32'(m_exp));
            check("done",      32'(done),      32'(m_done));
        end
        if (expired === 1'b1) exp_cnt++;
    end

    task automatic sync(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int e0;
        model_valid   = 0;
        rst           = 1'b1;
        present_state = 4'b0011;
        pause         = 1'b0;
        sync(3);
        check("reset_busy",    32'(busy), 32'd0);
        check("reset_t",       32'(t),    32'd0);
        rst = 1'b0;

        // Reset release with code 0011 loads a 1000 ms dwell.
        sync(1);
        check("rel_t",    32'(t),         32'd1000);
        check("rel_rem",  32'(remaining), 32'd1000);
        check("rel_busy", 32'(busy),      32'd1);
        sync(4);
        check("first_dec", 32'(remaining), 32'd999);
        e0 = exp_cnt;
        sync(3996 + 10);
        check("exp_once",  32'(exp_cnt - e0), 32'd1);
        check("exp_rem",   32'(remaining),    32'd0);
        check("exp_done",  32'(done),         32'd1);
        check("exp_busy",  32'(busy),         32'd0);
        sync(50);
        check("no_restart", 32'(exp_cnt - e0), 32'd1);
        check("done_holds", 32'(done),         32'd1);

        // Mid-dwell switch 0000 -> 0100.
        present_state = 4'b0000;
        sync(40);
        e0 = exp_cnt;
        present_state = 4'b0100;
        sync(1);
        check("sw_t",   32'(t),              32'd2000);
        check("sw_rem", 32'(remaining),      32'd2000);
        check("sw_exp", 32'(exp_cnt - e0),   32'd0);

        // Unlisted code parks in IDLE.
        present_state = 4'b0111;
        e0 = exp_cnt;
        sync(1);
        check("idle_t",    32'(t),    32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        sync(10000);
        check("idle_noexp", 32'(exp_cnt - e0), 32'd0);

        // Change lands on the expiry tick: the new dwell wins.
        present_state = 4'b0011;
        e0 = exp_cnt;
        sync(1);
        sync(3999);
        check("last_ms", 32'(remaining), 32'd1);
        present_state = 4'b0100;
        sync(1);
        check("coinc_exp", 32'(exp_cnt - e0), 32'd0);
        check("coinc_t",   32'(t),            32'd2000);
        check("coinc_rem", 32'(remaining),    32'd2000);

`ifdef TIMER_PAUSE_EN
        // 100-cycle freeze stretches the 1000 ms dwell to 4100 cycles.
        present_state = 4'b0011;
        e0 = exp_cnt;
        sync(1);
        sync(10);
        check("pre_pause", 32'(remaining), 32'd998);
        pause = 1'b1;
        sync(100);
        check("paused_rem", 32'(remaining), 32'd998);
        pause = 1'b0;
        sync(3989);
        check("pause_late_busy", 32'(busy),      32'd1);
        check("pause_late_rem",  32'(remaining), 32'd1);
        sync(1);
        check("pause_exp",  32'(expired), 32'd1);
        check("pause_done", 32'(done),    32'd1);
`endif

        // Reset mid-dwell aborts silently.
        present_state = 4'b0000;
        sync(20);
        rst = 1'b1;
        sync(1);
        check("rst_mid_busy", 32'(busy),    32'd0);
        check("rst_mid_exp",  32'(expired), 32'd0);
        rst = 1'b0;

        // Randomised segments, checked cycle by cycle against the model.
        for (int seg = 0; seg < 60; seg++) begin
            int   hold;
            logic [3:0] code;
            case ($urandom_range(0, 4))
                0: code = 4'b0000;
                1: code = 4'b0011;
                2: code = 4'b0100;
                3: code = 4'b0111;
                default: code = 4'($urandom_range(0, 15));
            endcase
            present_state = code;
            hold = (seg == 30) ? 4200 : int'($urandom_range(1, 200));
            for (int c = 0; c < hold; c++) begin
                pause = PAUSE_ON && ($urandom_range(0, 3) == 0);
                rst   = ($urandom_range(0, 499) == 0);
                sync(1);
            end
            rst   = 1'b0;
            pause = 1'b0;
        end
        sync(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
